// File: rtl/timer_scheduler_ci_pkg.sv
// timer_scheduler_ci_pkg: opcodes, field positions and FSM state type shared by the timer scheduler CI
package timer_scheduler_ci_pkg;
  localparam logic [3:0] OP_START_ONESHOT  = 4'd0;
  localparam logic [3:0] OP_START_PERIODIC = 4'd1;
  localparam logic [3:0] OP_STOP           = 4'd2;
  localparam logic [3:0] OP_READ           = 4'd3;
  localparam logic [3:0] OP_READ_PENDING   = 4'd4;
  localparam logic [3:0] OP_CLEAR_PENDING  = 4'd5;
  localparam logic [3:0] OP_WAIT           = 4'd6;
  localparam logic [3:0] OP_SET_MASK       = 4'd7;
  localparam int OPCODE_LSB = 4;
  localparam int OPCODE_MSB = 7;
  localparam logic [31:0] RESULT_ERROR = 32'hFFFF_FFFF;
  typedef enum logic {ST_IDLE, ST_WAITING} wait_state_e;
endpackage

// File: rtl/timer_scheduler_ci_if.sv
// timer_scheduler_ci_if: custom-instruction bus (start/cke/id/operands in, done/result out)
interface timer_scheduler_ci_if;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  modport master (output ciStart, ciCke, ciN, ciValueA, ciValueB, input ciDone, ciResult);
  modport slave (input ciStart, ciCke, ciN, ciValueA, ciValueB, output ciDone, ciResult);
endinterface

// File: rtl/timer_scheduler_ci_us_tick_gen.sv
// us_tick_gen: free-running microsecond prescaler; ports clock, reset (sync, active-high), usTick (1-clock pulse)
module us_tick_gen #(
  parameter int clockFrequencyInHz = 50000000
) (
  input  logic clock,
  input  logic reset,
  output logic usTick
);
  localparam logic [31:0] RELOAD_M1 = 32'(clockFrequencyInHz / 1000000 - 1);
  logic [31:0] cnt_q, cnt_d;
  assign usTick = cnt_q == '0;
  always_comb cnt_d = usTick ? RELOAD_M1 : cnt_q - 32'd1;
  always_ff @(posedge clock) cnt_q <= reset ? RELOAD_M1 : cnt_d;
endmodule

// File: rtl/timer_scheduler_ci.sv
// timer_scheduler_ci: multi-channel microsecond countdown timers behind one custom instruction
// Ports: clock, reset (sync, active-high), bus (CI slave); irq only when TIMER_SCHEDULER_IRQ_EN is defined.
module timer_scheduler_ci
  import timer_scheduler_ci_pkg::*;
#(
  parameter int          clockFrequencyInHz  = 50000000,
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int          nrOfTimers          = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  timer_scheduler_ci_if.slave  bus
`ifdef TIMER_SCHEDULER_IRQ_EN
  , output logic               irq
`endif
);
  localparam int N = nrOfTimers;
  localparam int idxBits = N > 1 ? $clog2(N) : 1;
  logic us_tick;
  logic [3:0] op;
  logic [idxBits-1:0] idx, widx_q, widx_d;
  logic idx_ok, accept, done_q, done_d;
  logic [31:0] res_q, res_d;
  logic [31:0] cnt_a [N];
  logic [N-1:0] sel, run_v, exp_v, pending_q, pending_d, clr, cons;
  wait_state_e state_q, state_d;
  logic unused_b;
  us_tick_gen #(.clockFrequencyInHz(clockFrequencyInHz)) u_tick (
    .clock(clock), .reset(reset), .usTick(us_tick)
  );
  assign unused_b = ^bus.ciValueB;
  assign op = bus.ciValueB[OPCODE_MSB:OPCODE_LSB];
  assign idx = bus.ciValueB[idxBits-1:0];
  assign idx_ok = 32'(idx) < 32'(N);
  assign accept = bus.ciStart & bus.ciCke & (bus.ciN == customInstructionId) & (state_q == ST_IDLE);
  assign sel = idx_ok ? N'(1) << idx : '0;
  for (genvar g = 0; g < N; g++) begin : ch
    logic [31:0] cnt_q, cnt_d, rel_q, rel_d;
    logic run_q, run_d, per_q, per_d, start, stop, hit;
    assign start = accept & sel[g] & ((op == OP_START_ONESHOT) | (op == OP_START_PERIODIC));
    assign stop = accept & sel[g] & (op == OP_STOP);
    assign hit = us_tick & run_q & (cnt_q == 32'd1);
    always_comb begin
      cnt_d = cnt_q;
      rel_d = rel_q;
      run_d = run_q;
      per_d = per_q;
      if (start) begin
        cnt_d = bus.ciValueA;
        rel_d = bus.ciValueA;
        run_d = |bus.ciValueA;
        per_d = op == OP_START_PERIODIC;
      end else if (stop) begin
        run_d = 1'b0;
      end else if (us_tick & run_q & (cnt_q != '0)) begin
        cnt_d = hit & per_q ? rel_q : cnt_q - 32'd1;
        run_d = ~hit | per_q;
      end
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q <= '0;
        rel_q <= '0;
        run_q <= 1'b0;
        per_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        rel_q <= rel_d;
        run_q <= run_d;
        per_q <= per_d;
      end
    end
    assign cnt_a[g] = cnt_q;
    assign run_v[g] = run_q;
    // A start/stop landing on the expiry cycle wins; that expiry is dropped.
    assign exp_v[g] = hit & ~start & ~stop;
  end
`ifdef TIMER_SCHEDULER_IRQ_EN
  logic [N-1:0] mask_q, mask_d;
  logic irq_q;
  assign irq = irq_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q <= '0;
      irq_q <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q <= |(pending_q & mask_q);
    end
  end
`endif
  always_comb begin
    state_d = state_q;
    widx_d = widx_q;
    done_d = 1'b0;
    res_d = '0;
    clr = '0;
    cons = '0;
`ifdef TIMER_SCHEDULER_IRQ_EN
    mask_d = mask_q;
`endif
    if (state_q == ST_WAITING) begin
      if (exp_v[widx_q]) begin
        state_d = ST_IDLE;
        done_d = 1'b1;
        res_d = 32'd1;
        cons = N'(1) << widx_q;
      end
    end else if (accept) begin
      done_d = 1'b1;
      case (op)
        OP_START_ONESHOT, OP_START_PERIODIC: begin
          res_d = idx_ok ? '0 : RESULT_ERROR;
          clr = sel;
        end
        OP_STOP, OP_READ: res_d = idx_ok ? cnt_a[idx] : RESULT_ERROR;
        OP_READ_PENDING: res_d = 32'(pending_q);
        OP_CLEAR_PENDING: begin
          res_d = 32'(pending_q);
          clr = bus.ciValueA[N-1:0];
        end
        OP_WAIT: begin
          // An expiry in the acceptance cycle counts as already pending, so it cannot be missed.
          if (!idx_ok) res_d = RESULT_ERROR;
          else if (pending_q[idx] | exp_v[idx]) begin
            res_d = 32'd1;
            cons = sel;
          end else if (!run_v[idx]) res_d = RESULT_ERROR;
          else begin
            done_d = 1'b0;
            state_d = ST_WAITING;
            widx_d = idx;
          end
        end
`ifdef TIMER_SCHEDULER_IRQ_EN
        OP_SET_MASK: begin
          res_d = 32'(mask_q);
          mask_d = bus.ciValueA[N-1:0];
        end
`endif
        default: res_d = '0;
      endcase
    end
    pending_d = ((pending_q & ~clr) | exp_v) & ~cons;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      widx_q <= '0;
      done_q <= 1'b0;
      res_q <= '0;
      pending_q <= '0;
    end else begin
      state_q <= state_d;
      widx_q <= widx_d;
      done_q <= done_d;
      res_q <= res_d;
      pending_q <= pending_d;
    end
  end
  assign bus.ciDone = done_q;
  assign bus.ciResult = res_q;
endmodule

// File: tb/tb_timer_scheduler_ci.sv
// tb_timer_scheduler_ci: directed self-checking bench for timer_scheduler_ci at 4 MHz (4 clocks per microsecond)
module tb_timer_scheduler_ci;
  import timer_scheduler_ci_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  timer_scheduler_ci_if bus();
`ifdef TIMER_SCHEDULER_IRQ_EN
  logic irq;
`endif
  timer_scheduler_ci #(
    .clockFrequencyInHz(4000000), .customInstructionId(8'd0), .nrOfTimers(4)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
`ifdef TIMER_SCHEDULER_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic ci(input logic [3:0] op, input int idx, input logic [31:0] a,
                    output logic d, output logic [31:0] r);
    bus.ciStart = 1'b1;
    bus.ciCke = 1'b1;
    bus.ciN = 8'd0;
    bus.ciValueA = a;
    bus.ciValueB = {24'd0, op, 4'(idx)};
    @(negedge clock);
    bus.ciStart = 1'b0;
    d = bus.ciDone;
    r = bus.ciResult;
  endtask

  task automatic tick_sync;
    int c = 0;
    while (dut.u_tick.usTick !== 1'b1 && c < 10) begin
      @(negedge clock);
      c++;
    end
    if (c >= 10) begin
      total++;
      $display("FAIL tick_sync timeout");
    end
  endtask

  task automatic test_reset;
    logic d;
    logic [31:0] r;
    total++; if (bus.ciDone !== 1'b0 || bus.ciResult !== 32'd0) $display("FAIL reset_outputs done=%b res=%h want 0/0", bus.ciDone, bus.ciResult); else passed++;
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (d !== 1'b1 || r !== 32'd0) $display("FAIL reset_pending done=%b res=%h want 1/0", d, r); else passed++;
    ci(OP_READ, 2, 0, d, r);
    total++; if (d !== 1'b1 || r !== 32'd0) $display("FAIL reset_count done=%b res=%h want 1/0", d, r); else passed++;
  endtask

  task automatic test_tick;
    int c;
    for (int k = 0; k < 2; k++) begin
      tick_sync();
      @(negedge clock);
      c = 1;
      while (dut.u_tick.usTick !== 1'b1 && c < 10) begin
        @(negedge clock);
        c++;
      end
      total++; if (c !== 4) $display("FAIL tick_period got %0d want 4", c); else passed++;
    end
  endtask

  task automatic test_oneshot_wait;
    logic d;
    logic [31:0] r;
    int t0, c;
    ci(OP_START_ONESHOT, 0, 32'd5, d, r);
    t0 = cyc;
    ci(OP_WAIT, 0, 0, d, r);
    total++; if (d !== 1'b0) $display("FAIL wait_blocks done=%b want 0", d); else passed++;
    c = 0;
    while (bus.ciDone !== 1'b1 && c < 40) begin
      @(negedge clock);
      c++;
    end
    total++; if (bus.ciDone !== 1'b1 || bus.ciResult !== 32'd1) $display("FAIL wait_done done=%b res=%h want 1/1", bus.ciDone, bus.ciResult); else passed++;
    total++; if (cyc - t0 < 17 || cyc - t0 > 21) $display("FAIL wait_latency got %0d want 17..21", cyc - t0); else passed++;
    @(negedge clock);
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'd0) $display("FAIL wait_pending_cleared got %h want 0", r); else passed++;
  endtask

  task automatic test_periodic;
    logic d;
    logic [31:0] r;
    ci(OP_START_PERIODIC, 2, 32'd3, d, r);
    repeat (48) @(negedge clock);
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h4) $display("FAIL periodic_pending got %h want 4", r); else passed++;
    ci(OP_CLEAR_PENDING, 0, 32'h4, d, r);
    total++; if (d !== 1'b1 || r !== 32'h4) $display("FAIL periodic_clear done=%b res=%h want 1/4", d, r); else passed++;
    repeat (16) @(negedge clock);
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h4) $display("FAIL periodic_reset_again got %h want 4", r); else passed++;
    ci(OP_STOP, 2, 0, d, r);
    ci(OP_CLEAR_PENDING, 0, 32'h4, d, r);
    total++; if (r !== 32'h4) $display("FAIL periodic_clear2 got %h want 4", r); else passed++;
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h0) $display("FAIL periodic_after_clear got %h want 0", r); else passed++;
  endtask

  task automatic test_stop;
    logic d;
    logic [31:0] r;
    ci(OP_START_ONESHOT, 1, 32'd100, d, r);
    repeat (40) @(negedge clock);
    ci(OP_STOP, 1, 0, d, r);
    total++; if (d !== 1'b1 || r !== 32'd90) $display("FAIL stop_result done=%b res=%0d want 1/90", d, r); else passed++;
    repeat (20) @(negedge clock);
    ci(OP_READ, 1, 0, d, r);
    total++; if (r !== 32'd90) $display("FAIL stop_read got %0d want 90", r); else passed++;
    ci(OP_START_ONESHOT, 1, 32'd0, d, r);
    ci(OP_READ, 1, 0, d, r);
    total++; if (r !== 32'd0) $display("FAIL zero_start_count got %0d want 0", r); else passed++;
    ci(OP_WAIT, 1, 0, d, r);
    total++; if (d !== 1'b1 || r !== RESULT_ERROR) $display("FAIL wait_stopped done=%b res=%h want 1/ffffffff", d, r); else passed++;
  endtask

  task automatic test_collisions;
    logic d;
    logic [31:0] r;
    ci(OP_START_ONESHOT, 0, 32'd1, d, r);
    repeat (8) @(negedge clock);
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h1) $display("FAIL coll_setup got %h want 1", r); else passed++;
    ci(OP_START_ONESHOT, 3, 32'd1, d, r);
    tick_sync();
    ci(OP_CLEAR_PENDING, 0, 32'h9, d, r);
    total++; if (r !== 32'h1) $display("FAIL coll_clear_result got %h want 1", r); else passed++;
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h8) $display("FAIL coll_set_wins got %h want 8", r); else passed++;
    ci(OP_CLEAR_PENDING, 0, 32'hF, d, r);
    ci(OP_START_ONESHOT, 0, 32'd1, d, r);
    tick_sync();
    ci(OP_START_ONESHOT, 0, 32'd50, d, r);
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'h0) $display("FAIL coll_restart_pending got %h want 0", r); else passed++;
    ci(OP_READ, 0, 0, d, r);
    total++; if (r !== 32'd50) $display("FAIL coll_restart_count got %0d want 50", r); else passed++;
  endtask

  task automatic test_misc;
    logic d;
    logic [31:0] r;
    ci(4'd8, 0, 32'h1234, d, r);
    total++; if (d !== 1'b1 || r !== 32'd0) $display("FAIL nop_opcode done=%b res=%h want 1/0", d, r); else passed++;
    bus.ciStart = 1'b1;
    bus.ciCke = 1'b1;
    bus.ciN = 8'h55;
    bus.ciValueB = {24'd0, OP_READ_PENDING, 4'd0};
    @(negedge clock);
    bus.ciStart = 1'b0;
    bus.ciN = 8'd0;
    total++; if (bus.ciDone !== 1'b0) $display("FAIL wrong_id done=%b want 0", bus.ciDone); else passed++;
    bus.ciStart = 1'b1;
    bus.ciCke = 1'b0;
    @(negedge clock);
    bus.ciStart = 1'b0;
    bus.ciCke = 1'b1;
    total++; if (bus.ciDone !== 1'b0) $display("FAIL cke_low done=%b want 0", bus.ciDone); else passed++;
  endtask

  task automatic test_reset_wait;
    logic d;
    logic [31:0] r;
    int n = 0;
    ci(OP_START_ONESHOT, 1, 32'd1000, d, r);
    ci(OP_WAIT, 1, 0, d, r);
    total++; if (d !== 1'b0) $display("FAIL rw_wait_blocks done=%b want 0", d); else passed++;
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (d !== 1'b0) $display("FAIL rw_ignored done=%b want 0", d); else passed++;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (bus.ciDone !== 1'b0) n++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (bus.ciDone !== 1'b0) n++;
    end
    total++; if (n !== 0) $display("FAIL rw_no_done got %0d pulses want 0", n); else passed++;
    ci(OP_READ, 1, 0, d, r);
    total++; if (d !== 1'b1 || r !== 32'd0) $display("FAIL rw_count done=%b res=%h want 1/0", d, r); else passed++;
    ci(OP_READ, 0, 0, d, r);
    total++; if (r !== 32'd0) $display("FAIL rw_count0 got %h want 0", r); else passed++;
    ci(OP_READ_PENDING, 0, 0, d, r);
    total++; if (r !== 32'd0) $display("FAIL rw_pending got %h want 0", r); else passed++;
  endtask

`ifdef TIMER_SCHEDULER_IRQ_EN
  task automatic test_irq;
    logic d;
    logic [31:0] r;
    total++; if (irq !== 1'b0) $display("FAIL irq_idle got %b want 0", irq); else passed++;
    ci(OP_SET_MASK, 0, 32'h1, d, r);
    total++; if (d !== 1'b1 || r !== 32'd0) $display("FAIL irq_old_mask done=%b res=%h want 1/0", d, r); else passed++;
    ci(OP_START_ONESHOT, 0, 32'd1, d, r);
    repeat (10) @(negedge clock);
    total++; if (irq !== 1'b1) $display("FAIL irq_assert got %b want 1", irq); else passed++;
  endtask
`endif

  initial begin
    bus.ciStart = 1'b0;
    bus.ciCke = 1'b0;
    bus.ciN = 8'd0;
    bus.ciValueA = '0;
    bus.ciValueB = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_tick();
    test_oneshot_wait();
    test_periodic();
    test_stop();
    test_collisions();
    test_misc();
    test_reset_wait();
`ifdef TIMER_SCHEDULER_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
